// File: rtl/nios2_ocimem_pkg.sv
// Shared types and constants for the Nios II OCI RAM arbiter.
//   state_t : arbiter FSM states
//   jcmd_t  : kind of JTAG command held in the pending slot
//   JDO_*   : bit positions of the fields inside the 38-bit jdo word
package nios2_ocimem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        J_RD   = 3'd1,
        J_RDW  = 3'd2,
        J_WR   = 3'd3,
        C_RD   = 3'd4,
        C_RDW  = 3'd5,
        C_WR   = 3'd6,
        C_DONE = 3'd7
    } state_t;

    typedef enum logic {
        JCMD_READ  = 1'b0,
        JCMD_WRITE = 1'b1
    } jcmd_t;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RD_BIT    = 34;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

    localparam logic [3:0] BE_ALL = 4'hF;

    // Alternating-priority grant: JTAG wins unless the CPU is also asking
    // and JTAG had the previous grant.
    function automatic logic jtag_wins(input logic j_req, input logic c_req,
                                       input logic last_j);
        return j_req && (!c_req || !last_j);
    endfunction

endpackage

// File: rtl/nios2_ocimem_jcmd_slot.sv
// JTAG command decode and single-entry pending slot.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   jdo, take_*                 debug command word and take strobes
//   pop                         arbiter consumed the pending entry
//   inc                         a JTAG access finished; advance mon_addr
//   valid, cmd, wdata           pending entry
//   addr                        current monitor address (mon_addr)
//   overrun                     sticky: a posted command was dropped
module nios2_ocimem_jcmd_slot
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              pop,
    input  logic              inc,
    output logic              valid,
    output jcmd_t             cmd,
    output logic [31:0]       wdata,
    output logic [ADDR_W-1:0] addr,
    output logic              overrun
);

    logic              valid_q, valid_d;
    jcmd_t             cmd_q, cmd_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              overrun_q, overrun_d;

    logic  post;
    jcmd_t post_cmd;

    // jdo bits with no meaning for this block
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    always_comb begin
        valid_d   = valid_q;
        cmd_d     = cmd_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        overrun_d = overrun_q;
        post      = 1'b0;
        post_cmd  = JCMD_READ;

        if (pop) valid_d = 1'b0;
        if (inc) addr_d = addr_q + 1'b1;

        // Strobe priority: action_a, then action_b, then no_action_a.
        // An address load overrides a same-cycle increment.
        if (take_action_ocimem_a) begin
            addr_d    = jdo[JDO_ADDR_LSB +: ADDR_W];
            overrun_d = 1'b0;
            post      = jdo[JDO_RD_BIT];
        end else if (take_action_ocimem_b) begin
            post     = 1'b1;
            post_cmd = JCMD_WRITE;
        end else if (take_no_action_ocimem_a) begin
            post = 1'b1;
        end

        // An entry being popped this cycle counts as free.
        if (post) begin
            if (valid_q && !pop) begin
                overrun_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                cmd_d   = post_cmd;
                wdata_d = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            cmd_q     <= JCMD_READ;
            wdata_q   <= '0;
            addr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid   = valid_q;
    assign cmd     = cmd_q;
    assign wdata   = wdata_q;
    assign addr    = addr_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Nios II OCI RAM controller: shares one single-port synchronous RAM
// (1-cycle read latency) between the JTAG debug path and a CPU slave.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   jdo, take_*                     JTAG debug commands
//   cpu_*                           Avalon-style CPU slave
//   ram_addr/wr/byteen/wdata/rdata  RAM port (all outputs registered)
//   mon_dreg, mon_valid             JTAG read data and its update pulse
//   jtag_overrun                    sticky dropped-command flag
//
// state  | meaning
// IDLE   | arbitrate between pending JTAG slot and CPU request
// J_RD   | JTAG read address on RAM
// J_RDW  | capture JTAG read data, advance mon_addr
// J_WR   | JTAG write strobe on RAM, advance mon_addr
// C_RD   | CPU read address on RAM
// C_RDW  | capture CPU read data
// C_WR   | CPU write strobe on RAM
// C_DONE | waitrequest low for the completion cycle
module nios2_ocimem_arbiter
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [3:0]        ram_byteen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       mon_dreg,
    output logic              mon_valid,
    output logic              jtag_overrun
);

    state_t            state_q, state_d;
    logic              last_j_q, last_j_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [3:0]        ram_byteen_q, ram_byteen_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       cpu_readdata_q, cpu_readdata_d;
    logic              cpu_waitrequest_q, cpu_waitrequest_d;
    logic [31:0]       mon_dreg_q, mon_dreg_d;
    logic              mon_valid_q, mon_valid_d;

    logic              slot_valid;
    jcmd_t             slot_cmd;
    logic [31:0]       slot_wdata;
    logic [ADDR_W-1:0] slot_addr;
    logic              slot_pop;
    logic              slot_inc;
    logic              cpu_req;

    nios2_ocimem_jcmd_slot #(
        .ADDR_W(ADDR_W)
    ) u_slot (
        .clk                    (clk),
        .reset                  (reset),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .pop                    (slot_pop),
        .inc                    (slot_inc),
        .valid                  (slot_valid),
        .cmd                    (slot_cmd),
        .wdata                  (slot_wdata),
        .addr                   (slot_addr),
        .overrun                (jtag_overrun)
    );

    assign cpu_req = cpu_read | cpu_write;

    // RAM outputs are loaded on state entry (from IDLE) and otherwise hold;
    // ram_wr defaults low so a write strobe lasts exactly one cycle.
    always_comb begin
        state_d        = state_q;
        last_j_d       = last_j_q;
        ram_addr_d     = ram_addr_q;
        ram_wr_d       = 1'b0;
        ram_byteen_d   = ram_byteen_q;
        ram_wdata_d    = ram_wdata_q;
        cpu_readdata_d = cpu_readdata_q;
        mon_dreg_d     = mon_dreg_q;
        mon_valid_d    = 1'b0;
        slot_pop       = 1'b0;
        slot_inc       = 1'b0;

        case (state_q)
            IDLE: begin
                if (jtag_wins(slot_valid, cpu_req, last_j_q)) begin
                    last_j_d   = 1'b1;
                    slot_pop   = 1'b1;
                    ram_addr_d = slot_addr;
                    if (slot_cmd == JCMD_WRITE) begin
                        state_d      = J_WR;
                        ram_wr_d     = 1'b1;
                        ram_wdata_d  = slot_wdata;
                        ram_byteen_d = BE_ALL;
                    end else begin
                        state_d = J_RD;
                    end
                end else if (cpu_req) begin
                    last_j_d   = 1'b0;
                    ram_addr_d = cpu_address;
                    // read+write together is handled as a write
                    if (cpu_write) begin
                        state_d      = C_WR;
                        ram_wr_d     = 1'b1;
                        ram_wdata_d  = cpu_writedata;
                        ram_byteen_d = cpu_byteenable;
                    end else begin
                        state_d = C_RD;
                    end
                end
            end
            J_RD:  state_d = J_RDW;
            J_RDW: begin
                mon_dreg_d  = ram_rdata;
                mon_valid_d = 1'b1;
                slot_inc    = 1'b1;
                state_d     = IDLE;
            end
            J_WR: begin
                slot_inc = 1'b1;
                state_d  = IDLE;
            end
            C_RD:  state_d = C_RDW;
            C_RDW: begin
                cpu_readdata_d = ram_rdata;
                state_d        = C_DONE;
            end
            C_WR:   state_d = C_DONE;
            C_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cpu_waitrequest_d = (state_d != C_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            last_j_q          <= 1'b0;
            ram_addr_q        <= '0;
            ram_wr_q          <= 1'b0;
            ram_byteen_q      <= '0;
            ram_wdata_q       <= '0;
            cpu_readdata_q    <= '0;
            cpu_waitrequest_q <= 1'b1;
            mon_dreg_q        <= '0;
            mon_valid_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            last_j_q          <= last_j_d;
            ram_addr_q        <= ram_addr_d;
            ram_wr_q          <= ram_wr_d;
            ram_byteen_q      <= ram_byteen_d;
            ram_wdata_q       <= ram_wdata_d;
            cpu_readdata_q    <= cpu_readdata_d;
            cpu_waitrequest_q <= cpu_waitrequest_d;
            mon_dreg_q        <= mon_dreg_d;
            mon_valid_q       <= mon_valid_d;
        end
    end

    assign ram_addr        = ram_addr_q;
    assign ram_wr          = ram_wr_q;
    assign ram_byteen      = ram_byteen_q;
    assign ram_wdata       = ram_wdata_q;
    assign cpu_readdata    = cpu_readdata_q;
    assign cpu_waitrequest = cpu_waitrequest_q;
    assign mon_dreg        = mon_dreg_q;
    assign mon_valid       = mon_valid_q;

endmodule
